rob: RTL and testbench

//  Reorder buffer. Allocates one tag (Paddr) per decoded instruction in program order,

---
 rtl/rob_pkg.sv | 9 +
 rtl/rob_ptr.sv | 38 +++
 rtl/rob.sv | 143 ++++++++++++++
 tb/tb_rob.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared configuration for the reorder buffer and its neighbours (RAT, issue queue).
// Holds the default depth and widths used by rob.
package rob_pkg;

   localparam int unsigned ROB_DEPTH_DEF      = 8;
   localparam int unsigned GPR_ADDR_WIDTH_DEF = 5;
   localparam int unsigned DATA_WIDTH_DEF     = 32;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer with increment and synchronous clear.
// The depth is a power of two, so a plain binary increment wraps the index and
// toggles the extra top bit.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   inc_i     advance pointer by one
//   clr_i     return pointer to zero (overrides inc_i)
//   ptr_o     {wrap, index}, TW+1 bits
module rob_ptr #(
   parameter int unsigned TW = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   input  logic        clr_i,
   output logic [TW:0] ptr_o
);

   logic [TW:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i)
         ptr_d = '0;
      else if (inc_i)
         ptr_d = ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates tags in program order, captures out-of-order
// writeback results, retires at most one entry per cycle in order.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   id_alloc_req/dst/wen       decode allocation request
//   rob_full, allocate_en      allocation status
//   rob_alloc_*_2rat           rename update to the RAT
//   wb_*                       writeback bus (tag, data, branch/exception flags)
//   rs1/rs2_Paddr              operand tag lookups; rob_rs*_ready/_data results
//   commit_en, rob_commit_*    in-order retirement, GPR write and flush triggers
module rob
   import rob_pkg::*;
#(
   parameter int unsigned ROB_DEPTH      = ROB_DEPTH_DEF,
   parameter int unsigned GPR_ADDR_WIDTH = GPR_ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
   localparam int unsigned TW            = $clog2(ROB_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_alloc_req,
   input  logic [GPR_ADDR_WIDTH-1:0] id_dst_addr,
   input  logic                      id_dst_wen,
   output logic                      rob_full,
   output logic                      allocate_en,
   output logic [TW-1:0]             rob_alloc_tag_2rat,
   output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
   output logic                      rob_alloc_dst_wen_2rat,
   input  logic                      wb_en,
   input  logic [TW-1:0]             wb_tag,
   input  logic [DATA_WIDTH-1:0]     wb_data,
   input  logic                      wb_br_taken,
   input  logic                      wb_exp,
   input  logic [TW-1:0]             rs1_Paddr,
   input  logic [TW-1:0]             rs2_Paddr,
   output logic                      rob_rs1_ready,
   output logic [DATA_WIDTH-1:0]     rob_rs1_data,
   output logic                      rob_rs2_ready,
   output logic [DATA_WIDTH-1:0]     rob_rs2_data,
   output logic                      commit_en,
   output logic [TW-1:0]             rob_commit_Paddr,
   output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
   output logic                      rob_commit_wen,
   output logic [DATA_WIDTH-1:0]     rob_commit_data,
   output logic                      rob_commit_br_taken,
   output logic                      rob_commit_exp_en
);

   logic                      valid_q    [ROB_DEPTH];
   logic                      done_q     [ROB_DEPTH];
   logic [GPR_ADDR_WIDTH-1:0] dst_addr_q [ROB_DEPTH];
   logic                      dst_wen_q  [ROB_DEPTH];
   logic [DATA_WIDTH-1:0]     data_q     [ROB_DEPTH];
   logic                      br_q       [ROB_DEPTH];
   logic                      exp_q      [ROB_DEPTH];

   logic [TW:0]   head_ptr, tail_ptr;
   logic [TW-1:0] head_idx, tail_idx;
   logic          flush;

   assign head_idx = head_ptr[TW-1:0];
   assign tail_idx = tail_ptr[TW-1:0];

   // Same index, opposite lap: every slot is occupied.
   assign rob_full = (head_idx == tail_idx) && (head_ptr[TW] != tail_ptr[TW]);

   assign commit_en   = valid_q[head_idx] && done_q[head_idx];
   assign flush       = commit_en && (br_q[head_idx] || exp_q[head_idx]);
   // Full is checked against registered state only, so a slot freed by this
   // cycle's commit cannot be handed out until the next cycle.
   assign allocate_en = id_alloc_req && !rob_full && !flush;

   assign rob_alloc_tag_2rat      = tail_idx;
   assign rob_alloc_dst_addr_2rat = id_dst_addr;
   assign rob_alloc_dst_wen_2rat  = id_dst_wen;

   assign rob_rs1_ready = valid_q[rs1_Paddr] && done_q[rs1_Paddr];
   assign rob_rs1_data  = data_q[rs1_Paddr];
   assign rob_rs2_ready = valid_q[rs2_Paddr] && done_q[rs2_Paddr];
   assign rob_rs2_data  = data_q[rs2_Paddr];

   assign rob_commit_Paddr         = head_idx;
   assign rob_commit_dst_addr_2rat = dst_addr_q[head_idx];
   assign rob_commit_wen           = commit_en && dst_wen_q[head_idx] && (dst_addr_q[head_idx] != '0);
   assign rob_commit_data          = data_q[head_idx];
   assign rob_commit_br_taken      = commit_en && br_q[head_idx];
   assign rob_commit_exp_en        = commit_en && exp_q[head_idx];

   rob_ptr #(.TW(TW)) u_head (
      .clk   (clk),
      .rst   (rst),
      .inc_i (commit_en),
      .clr_i (flush),
      .ptr_o (head_ptr)
   );

   rob_ptr #(.TW(TW)) u_tail (
      .clk   (clk),
      .rst   (rst),
      .inc_i (allocate_en),
      .clr_i (flush),
      .ptr_o (tail_ptr)
   );

   // The tail slot is never valid while allocation is allowed, so allocate
   // cannot collide with a writeback or commit on the same entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            valid_q[i]    <= 1'b0;
            done_q[i]     <= 1'b0;
            dst_addr_q[i] <= '0;
            dst_wen_q[i]  <= 1'b0;
            data_q[i]     <= '0;
            br_q[i]       <= 1'b0;
            exp_q[i]      <= 1'b0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            done_q[i]  <= 1'b0;
         end
      end else begin
         if (commit_en)
            valid_q[head_idx] <= 1'b0;
         if (wb_en && valid_q[wb_tag]) begin
            done_q[wb_tag] <= 1'b1;
            data_q[wb_tag] <= wb_data;
            br_q[wb_tag]   <= wb_br_taken;
            exp_q[wb_tag]  <= wb_exp;
         end
         if (allocate_en) begin
            valid_q[tail_idx]    <= 1'b1;
            done_q[tail_idx]     <= 1'b0;
            dst_addr_q[tail_idx] <= id_dst_addr;
            dst_wen_q[tail_idx]  <= id_dst_wen;
            br_q[tail_idx]       <= 1'b0;
            exp_q[tail_idx]      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rob.sv
// Directed vector bench for rob (depth 8, 5-bit GPR address, 32-bit data).
module tb_rob;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_alloc_req;
   logic [4:0]  id_dst_addr;
   logic        id_dst_wen;
   logic        rob_full, allocate_en;
   logic [2:0]  rob_alloc_tag_2rat;
   logic [4:0]  rob_alloc_dst_addr_2rat;
   logic        rob_alloc_dst_wen_2rat;
   logic        wb_en;
   logic [2:0]  wb_tag;
   logic [31:0] wb_data;
   logic        wb_br_taken, wb_exp;
   logic [2:0]  rs1_Paddr, rs2_Paddr;
   logic        rob_rs1_ready, rob_rs2_ready;
   logic [31:0] rob_rs1_data, rob_rs2_data;
   logic        commit_en;
   logic [2:0]  rob_commit_Paddr;
   logic [4:0]  rob_commit_dst_addr_2rat;
   logic        rob_commit_wen;
   logic [31:0] rob_commit_data;
   logic        rob_commit_br_taken, rob_commit_exp_en;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rob #(.ROB_DEPTH(8), .GPR_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .id_alloc_req             (id_alloc_req),
      .id_dst_addr              (id_dst_addr),
      .id_dst_wen               (id_dst_wen),
      .rob_full                 (rob_full),
      .allocate_en              (allocate_en),
      .rob_alloc_tag_2rat       (rob_alloc_tag_2rat),
      .rob_alloc_dst_addr_2rat  (rob_alloc_dst_addr_2rat),
      .rob_alloc_dst_wen_2rat   (rob_alloc_dst_wen_2rat),
      .wb_en                    (wb_en),
      .wb_tag                   (wb_tag),
      .wb_data                  (wb_data),
      .wb_br_taken              (wb_br_taken),
      .wb_exp                   (wb_exp),
      .rs1_Paddr                (rs1_Paddr),
      .rs2_Paddr                (rs2_Paddr),
      .rob_rs1_ready            (rob_rs1_ready),
      .rob_rs1_data             (rob_rs1_data),
      .rob_rs2_ready            (rob_rs2_ready),
      .rob_rs2_data             (rob_rs2_data),
      .commit_en                (commit_en),
      .rob_commit_Paddr         (rob_commit_Paddr),
      .rob_commit_dst_addr_2rat (rob_commit_dst_addr_2rat),
      .rob_commit_wen           (rob_commit_wen),
      .rob_commit_data          (rob_commit_data),
      .rob_commit_br_taken      (rob_commit_br_taken),
      .rob_commit_exp_en        (rob_commit_exp_en)
   );

   typedef struct {
      logic        req;
      logic [4:0]  dst;
      logic        wen;
      logic        wbe;
      logic [2:0]  wtag;
      logic [31:0] wdata;
      logic        wbr;
      logic        wexp;
      logic [2:0]  rs1;
      logic        full;
      logic        aen;
      logic [2:0]  atag;
      logic        cen;
      logic [2:0]  cpa;
      logic        cwen;
      logic        cbr;
      logic        cexp;
      logic [31:0] cdata;
      logic        r1rdy;
      logic [31:0] r1data;
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t mk(
      input int req, input int dst, input int wen,
      input int wbe, input int wtag, input int wdata, input int wbr, input int wexp,
      input int rs1,
      input int full, input int aen, input int atag,
      input int cen, input int cpa, input int cwen, input int cbr, input int cexp, input int cdata,
      input int r1rdy, input int r1data);
      vec_t v;
      v.req = 1'(req);   v.dst = 5'(dst);     v.wen = 1'(wen);
      v.wbe = 1'(wbe);   v.wtag = 3'(wtag);   v.wdata = 32'(wdata);
      v.wbr = 1'(wbr);   v.wexp = 1'(wexp);   v.rs1 = 3'(rs1);
      v.full = 1'(full); v.aen = 1'(aen);     v.atag = 3'(atag);
      v.cen = 1'(cen);   v.cpa = 3'(cpa);     v.cwen = 1'(cwen);
      v.cbr = 1'(cbr);   v.cexp = 1'(cexp);   v.cdata = 32'(cdata);
      v.r1rdy = 1'(r1rdy); v.r1data = 32'(r1data);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic drive(input logic req, input logic [4:0] dst, input logic wen,
                        input logic wbe, input logic [2:0] wtag, input logic [31:0] wdata,
                        input logic wbr, input logic wexp, input logic [2:0] rs1);
      id_alloc_req = req; id_dst_addr = dst; id_dst_wen = wen;
      wb_en = wbe; wb_tag = wtag; wb_data = wdata; wb_br_taken = wbr; wb_exp = wexp;
      rs1_Paddr = rs1; rs2_Paddr = rs1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      tbl[0] = mk(0,0,0, 0,0,0,0,0, 0, 0,0,0, 0,0,0,0,0,0, 0,0);
      // Fill all 8 entries; entry 3 targets x0
      for (int i = 0; i < 8; i++)
         tbl[1+i] = mk(1, (i == 3) ? 0 : i + 1, 1, 0,0,0,0,0, 0, 0,1,i, 0,0,0,0,0,0, 0,0);
      // 9th request refused
      tbl[9]  = mk(1,9,1,  0,0,0,0,0,       0, 1,0,0, 0,0,0,0,0,0,       0,0);
      // Out-of-order writeback 2,1,0; no same-cycle forwarding
      tbl[10] = mk(0,0,0,  1,2,'h22,0,0,    2, 1,0,0, 0,0,0,0,0,0,       0,0);
      tbl[11] = mk(0,0,0,  1,1,'h11,0,0,    2, 1,0,0, 0,0,0,0,0,0,       1,'h22);
      tbl[12] = mk(0,0,0,  1,0,'h10,0,0,    1, 1,0,0, 0,0,0,0,0,0,       1,'h11);
      // Full with head done: commit, allocate refused this cycle
      tbl[13] = mk(1,10,1, 0,0,0,0,0,       0, 1,0,0, 1,0,1,0,0,'h10,    1,'h10);
      // Granted next cycle with old head tag, commit of tag 1 alongside
      tbl[14] = mk(1,10,1, 0,0,0,0,0,       0, 0,1,0, 1,1,1,0,0,'h11,    0,'h10);
      tbl[15] = mk(0,0,0,  0,0,0,0,0,       2, 0,0,1, 1,2,1,0,0,'h22,    1,'h22);
      // Writeback to freed tag 1 is ignored
      tbl[16] = mk(0,0,0,  1,1,'hdead,0,0,  1, 0,0,1, 0,3,0,0,0,0,       0,'h11);
      tbl[17] = mk(0,0,0,  1,3,'h33,0,0,    1, 0,0,1, 0,3,0,0,0,0,       0,'h11);
      // Commit of x0 destination: no GPR write
      tbl[18] = mk(0,0,0,  0,0,0,0,0,       3, 0,0,1, 1,3,0,0,0,'h33,    1,'h33);
      // Branch at head with alloc request in the same cycle
      tbl[19] = mk(0,0,0,  1,4,'h44,1,0,    4, 0,0,1, 0,4,0,0,0,0,       0,0);
      tbl[20] = mk(1,7,1,  0,0,0,0,0,       4, 0,0,1, 1,4,1,1,0,'h44,    1,'h44);
      tbl[21] = mk(1,7,1,  0,0,0,0,0,       4, 0,1,0, 0,0,0,0,0,'h10,    0,'h44);
      // Exception at head also flushes
      tbl[22] = mk(0,0,0,  1,0,'h55,0,1,    0, 0,0,1, 0,0,0,0,0,'h10,    0,'h10);
      tbl[23] = mk(1,2,1,  0,0,0,0,0,       0, 0,0,1, 1,0,1,0,1,'h55,    1,'h55);
      tbl[24] = mk(0,0,0,  0,0,0,0,0,       0, 0,0,0, 0,0,0,0,0,'h55,    0,'h55);

      for (int n = 0; n < 25; n++) begin
         drive(tbl[n].req, tbl[n].dst, tbl[n].wen, tbl[n].wbe, tbl[n].wtag,
               tbl[n].wdata, tbl[n].wbr, tbl[n].wexp, tbl[n].rs1);
         #2;
         chk($sformatf("v%0d rob_full", n),      32'(rob_full),            32'(tbl[n].full));
         chk($sformatf("v%0d allocate_en", n),   32'(allocate_en),         32'(tbl[n].aen));
         chk($sformatf("v%0d alloc_tag", n),     32'(rob_alloc_tag_2rat),  32'(tbl[n].atag));
         chk($sformatf("v%0d alloc_dst", n),     32'(rob_alloc_dst_addr_2rat), 32'(tbl[n].dst));
         chk($sformatf("v%0d alloc_wen", n),     32'(rob_alloc_dst_wen_2rat),  32'(tbl[n].wen));
         chk($sformatf("v%0d commit_en", n),     32'(commit_en),           32'(tbl[n].cen));
         chk($sformatf("v%0d commit_Paddr", n),  32'(rob_commit_Paddr),    32'(tbl[n].cpa));
         chk($sformatf("v%0d commit_wen", n),    32'(rob_commit_wen),      32'(tbl[n].cwen));
         chk($sformatf("v%0d commit_br", n),     32'(rob_commit_br_taken), 32'(tbl[n].cbr));
         chk($sformatf("v%0d commit_exp", n),    32'(rob_commit_exp_en),   32'(tbl[n].cexp));
         chk($sformatf("v%0d commit_data", n),   rob_commit_data,          tbl[n].cdata);
         chk($sformatf("v%0d rs1_ready", n),     32'(rob_rs1_ready),       32'(tbl[n].r1rdy));
         chk($sformatf("v%0d rs1_data", n),      rob_rs1_data,             tbl[n].r1data);
         chk($sformatf("v%0d rs2_ready", n),     32'(rob_rs2_ready),       32'(tbl[n].r1rdy));
         chk($sformatf("v%0d rs2_data", n),      rob_rs2_data,             tbl[n].r1data);
         tick();
      end

      // Wrap: 20 alloc/commit pairs, one entry in flight, starting from empty at 0
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 5'(k % 31 + 1), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
         #2;
         chk($sformatf("wrap%0d alloc_en", k),  32'(allocate_en),        32'd1);
         chk($sformatf("wrap%0d alloc_tag", k), 32'(rob_alloc_tag_2rat), 32'(k % 8));
         chk($sformatf("wrap%0d full", k),      32'(rob_full),           32'd0);
         chk($sformatf("wrap%0d commit_en", k), 32'(commit_en),          (k > 0) ? 32'd1 : 32'd0);
         if (k > 0) begin
            chk($sformatf("wrap%0d commit_Paddr", k), 32'(rob_commit_Paddr), 32'((k - 1) % 8));
            chk($sformatf("wrap%0d commit_data", k),  rob_commit_data,       32'(100 + k - 1));
         end
         tick();
         drive(1'b0, '0, 1'b0, 1'b1, 3'(k % 8), 32'(100 + k), 1'b0, 1'b0, '0);
         #2;
         chk($sformatf("wrap%0d wb commit_en", k), 32'(commit_en), 32'd0);
         chk($sformatf("wrap%0d wb full", k),      32'(rob_full),  32'd0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      #2;
      chk("wrap last commit_en",    32'(commit_en),        32'd1);
      chk("wrap last commit_Paddr", 32'(rob_commit_Paddr), 32'd3);
      chk("wrap last commit_data",  rob_commit_data,       32'd119);
      chk("wrap last commit_wen",   32'(rob_commit_wen),   32'd1);
      tick();
      #2;
      chk("wrap empty commit_en", 32'(commit_en),          32'd0);
      chk("wrap empty alloc_tag", 32'(rob_alloc_tag_2rat), 32'd4);
      chk("wrap empty full",      32'(rob_full),           32'd0);
      tick();

      // Mid-operation reset discards in-flight entries
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 5'(k + 1), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b1, 3'd4, 32'h77, 1'b0, 1'b0, 3'd4);
      tick();
      #2;
      chk("prereset rs1_ready", 32'(rob_rs1_ready), 32'd1);
      chk("prereset commit_en", 32'(commit_en),     32'd1);
      rst = 1'b1;
      drive(1'b1, 5'd9, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 3'd4);
      tick();
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 3'd4);
      #2;
      chk("postreset commit_en",   32'(commit_en),          32'd0);
      chk("postreset alloc_tag",   32'(rob_alloc_tag_2rat), 32'd0);
      chk("postreset full",        32'(rob_full),           32'd0);
      chk("postreset rs1_ready",   32'(rob_rs1_ready),      32'd0);
      chk("postreset rs1_data",    rob_rs1_data,            32'd0);
      chk("postreset commit_data", rob_commit_data,         32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
